// File: rtl/test_status_mmio.sv
// Test-status peripheral: software reports checkpoints and a final pass/fail word over
// the data-memory bus; a watchdog flags a hung test when checkpoints stop arriving.
module test_status_mmio #(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0100,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  input  logic        mmio_we,
  input  logic        mmio_re,
  output logic [31:0] mmio_rdata,
  output logic [31:0] checkpoint,
  output logic        checkpoint_valid,
  output logic        test_done,
  output logic        test_pass,
  output logic        test_timeout,
  output logic [10:0] fail_test_num,
  output logic [1:0]  dbg_state
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUNNING = 2'd0,
    ST_PASSED  = 2'd1,
    ST_FAILED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t          r_state;
  logic [WD_W-1:0] r_wd;
  logic [31:0]     r_cycles;
  logic [15:0]     r_count;
  logic [31:0]     r_checkpoint;
  logic            r_ckpt_valid;
  logic [10:0]     r_fail_num;
  logic [31:0]     r_rdata;
  logic            r_done;
  logic            r_pass;
  logic            r_timeout;

  logic        w_sel;
  logic [5:0]  w_off;
  logic        w_running;
  logic        w_wr_ckpt;
  logic        w_wr_result;
  logic        w_expire;
  logic [31:0] w_rd_data;
  logic        w_unused_addr;

  assign w_sel         = (mmio_addr[31:8] == BASE_ADDR[31:8]);
  assign w_off         = mmio_addr[7:2];
  assign w_unused_addr = &{1'b0, mmio_addr[1:0]};
  assign w_running     = (r_state == ST_RUNNING);
  assign w_wr_ckpt     = w_running && mmio_we && w_sel && (w_off == 6'h00);
  assign w_wr_result   = w_running && mmio_we && w_sel && (w_off == 6'h01);
  assign w_expire      = (r_wd == WD_LAST);

  // Read mux looks only at current register values, so a same-cycle write is not visible.
  always_comb begin
    w_rd_data = '0;
    if (w_sel) begin
      case (w_off)
        6'h00:   w_rd_data = r_checkpoint;
        6'h01:   w_rd_data = {20'b0, r_fail_num, r_pass};
        6'h02:   w_rd_data = {28'b0, r_timeout, (r_state == ST_FAILED), r_pass, w_running};
        6'h03:   w_rd_data = r_cycles;
        6'h04:   w_rd_data = {16'b0, r_count};
        default: w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUNNING;
      r_wd         <= '0;
      r_cycles     <= '0;
      r_count      <= '0;
      r_checkpoint <= '0;
      r_ckpt_valid <= 1'b0;
      r_fail_num   <= '0;
      r_rdata      <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      if (r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
      r_ckpt_valid <= w_wr_ckpt;
      if (mmio_re) r_rdata <= w_rd_data;

      // A RESULT write takes priority over watchdog expiry in the same cycle.
      case (r_state)
        ST_RUNNING: begin
          if (w_wr_result) begin
            r_done <= 1'b1;
            if (mmio_wdata[0]) begin
              r_state <= ST_PASSED;
              r_pass  <= 1'b1;
            end else begin
              r_state    <= ST_FAILED;
              r_fail_num <= mmio_wdata[11:1];
            end
          end else if (w_wr_ckpt) begin
            r_checkpoint <= mmio_wdata;
            r_count      <= r_count + 16'd1;
            r_wd         <= '0;
          end else if (w_expire) begin
            r_state   <= ST_TIMEOUT;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mmio_rdata       = r_rdata;
  assign checkpoint       = r_checkpoint;
  assign checkpoint_valid = r_ckpt_valid;
  assign test_done        = r_done;
  assign test_pass        = r_pass;
  assign test_timeout     = r_timeout;
  assign fail_test_num    = r_fail_num;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_test_status_mmio.sv
// Bench for test_status_mmio: directed scenarios followed by randomized bus traffic,
// every cycle compared against an edge-indexed reference model of the register map.
module tb_test_status_mmio;

  localparam int unsigned T = 16;
  localparam logic [31:0] BASE = 32'h8000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mmio_addr = '0;
  logic [31:0] mmio_wdata = '0;
  logic        mmio_we = 1'b0;
  logic        mmio_re = 1'b0;
  logic [31:0] mmio_rdata;
  logic [31:0] checkpoint;
  logic        checkpoint_valid;
  logic        test_done;
  logic        test_pass;
  logic        test_timeout;
  logic [10:0] fail_test_num;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  test_status_mmio #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_we(mmio_we), .mmio_re(mmio_re), .mmio_rdata(mmio_rdata),
    .checkpoint(checkpoint), .checkpoint_valid(checkpoint_valid),
    .test_done(test_done), .test_pass(test_pass), .test_timeout(test_timeout),
    .fail_test_num(fail_test_num), .dbg_state(dbg_state)
  );

  // Reference model: mode 0 running, 1 passed, 2 failed, 3 timed out.
  int          m_mode;
  logic [31:0] m_ckpt;
  logic [15:0] m_count;
  logic [10:0] m_fail;
  longint      m_t;
  longint      m_kick;
  logic        m_valid;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [7:0] off;
    off = {a[7:2], 2'b00};
    if (a[31:8] != BASE[31:8]) return 32'h0;
    case (off)
      8'h00: return m_ckpt;
      8'h04: return {20'b0, m_fail, (m_mode == 1)};
      8'h08: return {28'b0, (m_mode == 3), (m_mode == 2), (m_mode == 1), (m_mode == 0)};
      8'h0C: return (m_t >= 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_t[31:0];
      8'h10: return {16'b0, m_count};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic we, input logic re,
                            input logic [31:0] a, input logic [31:0] d);
    logic       sel;
    logic [7:0] off;
    if (r) begin
      m_mode = 0; m_ckpt = '0; m_count = '0; m_fail = '0;
      m_t = 0; m_kick = 0; m_valid = 1'b0; m_rdata = '0;
      return;
    end
    if (re) m_rdata = m_read(a);
    m_t++;
    m_valid = 1'b0;
    sel = (a[31:8] == BASE[31:8]);
    off = {a[7:2], 2'b00};
    if (m_mode == 0) begin
      if (we && sel && off == 8'h04) begin
        if (d[0]) m_mode = 1;
        else begin
          m_mode = 2;
          m_fail = d[11:1];
        end
      end else if (we && sel && off == 8'h00) begin
        m_ckpt = d;
        m_count = m_count + 16'd1;
        m_kick = m_t;
        m_valid = 1'b1;
      end else if (m_t - m_kick >= longint'(T)) begin
        m_mode = 3;
      end
    end
  endtask

  task automatic check_all();
    chk("done", {31'b0, test_done}, {31'b0, (m_mode != 0)});
    chk("pass", {31'b0, test_pass}, {31'b0, (m_mode == 1)});
    chk("timeout", {31'b0, test_timeout}, {31'b0, (m_mode == 3)});
    chk("fail_num", {21'b0, fail_test_num}, {21'b0, m_fail});
    chk("checkpoint", checkpoint, m_ckpt);
    chk("ckpt_valid", {31'b0, checkpoint_valid}, {31'b0, m_valid});
    chk("rdata", mmio_rdata, m_rdata);
  endtask

  task automatic step(input logic r, input logic we, input logic re,
                      input logic [31:0] a, input logic [31:0] d);
    rst = r; mmio_we = we; mmio_re = re; mmio_addr = a; mmio_wdata = d;
    @(posedge clk);
    model_edge(r, we, re, a, d);
    #1;
    rst = 1'b0; mmio_we = 1'b0; mmio_re = 1'b0;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, BASE, 32'h1);
  endtask

  initial begin
    int rise;
    logic [31:0] addr_tab[8];
    addr_tab[0] = BASE + 32'h00; addr_tab[1] = BASE + 32'h04;
    addr_tab[2] = BASE + 32'h08; addr_tab[3] = BASE + 32'h0C;
    addr_tab[4] = BASE + 32'h10; addr_tab[5] = BASE + 32'hF0;
    addr_tab[6] = BASE + 32'h101; addr_tab[7] = BASE + 32'h02;

    // Reset state
    do_reset();
    do_reset();
    chk("rst_rdata", mmio_rdata, 32'h0);
    chk("rst_done", {31'b0, test_done}, 32'h0);

    // Checkpoint, pulse, COUNT readback
    step(1'b0, 1'b1, 1'b0, BASE, 32'd300);
    chk("ckpt300", checkpoint, 32'd300);
    chk("ckpt_pulse", {31'b0, checkpoint_valid}, 32'd1);
    idle();
    chk("ckpt_pulse_end", {31'b0, checkpoint_valid}, 32'd0);
    step(1'b0, 1'b0, 1'b1, BASE + 32'h10, 32'h0);
    idle();
    chk("count_rd", mmio_rdata, 32'd1);

    // FAILED is sticky; later RESULT ignored
    step(1'b0, 1'b1, 1'b0, BASE + 32'h04, (32'd2 << 1));
    chk("fail_done", {31'b0, test_done}, 32'd1);
    chk("fail_num2", {21'b0, fail_test_num}, 32'd2);
    step(1'b0, 1'b1, 1'b0, BASE + 32'h04, 32'd1);
    step(1'b0, 1'b0, 1'b1, BASE + 32'h08, 32'h0);
    idle();
    chk("status_failed", mmio_rdata, 32'h4);
    chk("fail_nopass", {31'b0, test_pass}, 32'd0);

    // PASSED freezes checkpoint
    do_reset();
    step(1'b0, 1'b1, 1'b0, BASE + 32'h04, 32'd1);
    chk("pass_flag", {31'b0, test_pass}, 32'd1);
    step(1'b0, 1'b1, 1'b0, BASE, 32'd77);
    chk("pass_ckpt_frozen", checkpoint, 32'd0);

    // Timeout with no writes
    do_reset();
    rise = 0;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (test_timeout && rise == 0) rise = i;
    end
    chk("timeout_at", rise, T);

    // Checkpoint at cycle 10 moves timeout
    do_reset();
    rise = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 10) step(1'b0, 1'b1, 1'b0, BASE, 32'hABCD);
      else idle();
      if (test_timeout && rise == 0) rise = i;
    end
    chk("timeout_moved", rise, T + 10);

    // RESULT on the expiry cycle wins
    do_reset();
    for (int i = 1; i < int'(T); i++) idle();
    step(1'b0, 1'b1, 1'b0, BASE + 32'h04, 32'd1);
    chk("expiry_pass", {31'b0, test_pass}, 32'd1);
    idle();
    chk("expiry_no_to", {31'b0, test_timeout}, 32'd0);

    // Reset while FAILED, then CYCLES read
    do_reset();
    step(1'b0, 1'b1, 1'b0, BASE + 32'h04, 32'h6);
    do_reset();
    chk("rst_clear_done", {31'b0, test_done}, 32'd0);
    chk("rst_clear_fail", {21'b0, fail_test_num}, 32'd0);
    for (int i = 1; i <= 4; i++) idle();
    step(1'b0, 1'b0, 1'b1, BASE + 32'h0C, 32'h0);
    idle();
    chk("cycles_rd", {31'b0, (mmio_rdata == 32'd4 || mmio_rdata == 32'd5)}, 32'd1);

    // Randomized traffic
    for (int ep = 0; ep < 15; ep++) begin
      do_reset();
      for (int s = 0; s < 50; s++) begin
        logic [31:0] a;
        logic [31:0] d;
        logic we;
        logic re;
        int k;
        k = $urandom_range(0, 99);
        d = $urandom;
        re = ($urandom_range(0, 1) == 1);
        we = 1'b1;
        if (k < 4) a = BASE + 32'h04;
        else if (k < 35) a = (k < 30) ? BASE : BASE + 32'h03;
        else if (k < 50) a = addr_tab[$urandom_range(2, 7)];
        else begin
          a = addr_tab[$urandom_range(0, 7)];
          we = 1'b0;
        end
        step((k == 99), we, re, a, d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
